// File: rtl/alu_issue.sv
// alu_issue: exec-stage issue buffer feeding the ALU.
// Decodes a MIPS-format instruction plus register-file read data into an ALU
// operand bundle and holds it in a 2-entry FIFO skid buffer.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         upstream handshake (in_ready is registered)
//   instr, rs_data, rt_data   instruction word and register operands
//   flush                     drops every buffered entry and any same-cycle accept
//   out_valid/out_ready       downstream handshake for the head entry
//   aluop, src1, src2, shamt  head bundle operands
//   illegal                   head bundle came from an undecodable instruction

`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD  5'd0
`define ALUOP_SUB  5'd1
`define ALUOP_SLL  5'd2
`define ALUOP_MOV  5'd3
`define ALUOP_ORI  5'd4
`define ALUOP_LUI  5'd5
`define ALUOP_JUMP 5'd6
`endif

module alu_issue #(
    parameter int unsigned REG_SIZE = `REG_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [REG_SIZE-1:0] rs_data,
    input  logic [REG_SIZE-1:0] rt_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          aluop,
    output logic [REG_SIZE-1:0] src1,
    output logic [REG_SIZE-1:0] src2,
    output logic [4:0]          shamt,
    output logic                illegal
);

    typedef struct packed {
        logic [4:0]          aluop;
        logic [REG_SIZE-1:0] src1;
        logic [REG_SIZE-1:0] src2;
        logic [4:0]          shamt;
        logic                illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam bundle_t RESET_BUNDLE = '{
        aluop:   `ALUOP_ADD,
        src1:    '0,
        src2:    '0,
        shamt:   '0,
        illegal: 1'b0
    };

    state_t  state_q, state_d;
    bundle_t head_q, skid_q, dec;
    logic    in_ready_q;
    logic    accept, pop;
    logic    load_head, load_skid, head_from_skid;

    logic [5:0] opcode, funct;
    logic [4:0] unused_rs_field;

    assign opcode          = instr[31:26];
    assign funct           = instr[5:0];
    // rs is already resolved into rs_data by the register file.
    assign unused_rs_field = instr[25:21];

    // ---------------- decode ----------------
    always_comb begin
        dec       = RESET_BUNDLE;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: begin
                        dec.aluop = `ALUOP_ADD;
                        dec.src1  = rs_data;
                        dec.src2  = rt_data;
                    end
                    6'h22: begin
                        dec.aluop = `ALUOP_SUB;
                        dec.src1  = rs_data;
                        dec.src2  = rt_data;
                    end
                    6'h00: begin
                        dec.aluop = `ALUOP_SLL;
                        dec.src1  = rt_data;
                        dec.shamt = instr[10:6];
                    end
                    6'h25: begin
                        // OR with rt=$0 is a register move; any other rt is unsupported.
                        if (instr[20:16] == 5'd0) begin
                            dec.aluop = `ALUOP_MOV;
                            dec.src1  = rs_data;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h08, 6'h23, 6'h2B: begin
                dec.aluop = `ALUOP_ADD;
                dec.src1  = rs_data;
                dec.src2  = {{(REG_SIZE-16){instr[15]}}, instr[15:0]};
            end
            6'h0D: begin
                dec.aluop = `ALUOP_ORI;
                dec.src1  = rs_data;
                dec.src2  = {{(REG_SIZE-16){1'b0}}, instr[15:0]};
            end
            6'h0F: begin
                dec.aluop = `ALUOP_LUI;
                dec.src2  = {{(REG_SIZE-16){1'b0}}, instr[15:0]};
            end
            6'h02: begin
                dec.aluop = `ALUOP_JUMP;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // ---------------- buffer control ----------------
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready_q && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_from_skid = 1'b1;
                    if (accept) begin
                        load_skid = 1'b1;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d        = EMPTY;
            load_head      = 1'b0;
            load_skid      = 1'b0;
            head_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= RESET_BUNDLE;
            skid_q     <= RESET_BUNDLE;
        end else begin
            state_q    <= state_d;
            // Registered ready: depends only on the next occupancy, never on out_ready directly.
            in_ready_q <= (state_d != FULL);
            if (load_head) begin
                head_q <= dec;
            end else if (head_from_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign in_ready = in_ready_q;
    assign aluop    = head_q.aluop;
    assign src1     = head_q.src1;
    assign src2     = head_q.src2;
    assign shamt    = head_q.shamt;
    assign illegal  = head_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed plus randomized checks of alu_issue against a
// queue-based reference model of the decode rules and FIFO behaviour.

`ifndef ALUOP_ADD
`define ALUOP_ADD  5'd0
`define ALUOP_SUB  5'd1
`define ALUOP_SLL  5'd2
`define ALUOP_MOV  5'd3
`define ALUOP_ORI  5'd4
`define ALUOP_LUI  5'd5
`define ALUOP_JUMP 5'd6
`endif

module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  aluop;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic        illegal;

    alu_issue #(.REG_SIZE(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluop     (aluop),
        .src1      (src1),
        .src2      (src2),
        .shamt     (shamt),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  sh;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    bit   last_held = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode written directly from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] rs,
                                        input logic [31:0] rt);
        exp_t             e;
        int unsigned      op;
        int unsigned      fn;
        logic signed [31:0] imm_s;
        logic [31:0]      imm_z;
        op    = i[31:26];
        fn    = i[5:0];
        imm_s = $signed(i[15:0]);
        imm_z = {16'h0000, i[15:0]};
        e = '{op: `ALUOP_ADD, s1: 32'd0, s2: 32'd0, sh: 5'd0, ill: 1'b0};
        if (op == 0 && fn == 'h20) e = '{`ALUOP_ADD, rs, rt, 5'd0, 1'b0};
        else if (op == 0 && fn == 'h22) e = '{`ALUOP_SUB, rs, rt, 5'd0, 1'b0};
        else if (op == 0 && fn == 'h00) e = '{`ALUOP_SLL, rt, 32'd0, i[10:6], 1'b0};
        else if (op == 0 && fn == 'h25 && i[20:16] == 0) e = '{`ALUOP_MOV, rs, 32'd0, 5'd0, 1'b0};
        else if (op == 'h08 || op == 'h23 || op == 'h2B) e = '{`ALUOP_ADD, rs, imm_s, 5'd0, 1'b0};
        else if (op == 'h0D) e = '{`ALUOP_ORI, rs, imm_z, 5'd0, 1'b0};
        else if (op == 'h0F) e = '{`ALUOP_LUI, 32'd0, imm_z, 5'd0, 1'b0};
        else if (op == 'h02) e = '{`ALUOP_JUMP, 32'd0, 32'd0, 5'd0, 1'b0};
        else e.ill = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] b;
        b = $urandom;
        case ($urandom_range(0, 11))
            0:  return {6'h00, b[25:6], 6'h20};
            1:  return {6'h00, b[25:6], 6'h22};
            2:  return {6'h00, b[25:6], 6'h00};
            3:  return {6'h00, b[25:21], 5'd0, b[15:6], 6'h25};
            4:  return {6'h00, b[25:6], 6'h25};
            5:  return {6'h08, b[25:0]};
            6:  return {6'h23, b[25:0]};
            7:  return {6'h2B, b[25:0]};
            8:  return {6'h0D, b[25:0]};
            9:  return {6'h0F, b[25:0]};
            10: return {6'h02, b[25:0]};
            default: return b;
        endcase
    endfunction

    task automatic check_outputs();
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() != 0) begin
            check("head.aluop", {27'd0, aluop}, {27'd0, q[0].op});
            check("head.src1", src1, q[0].s1);
            check("head.src2", src2, q[0].s2);
            check("head.shamt", {27'd0, shamt}, {27'd0, q[0].sh});
            check("head.illegal", {31'd0, illegal}, {31'd0, q[0].ill});
        end
    endtask

    // One clock: model the handshake from the model's own occupancy, then compare.
    task automatic step();
        bit   acc;
        bit   pp;
        exp_t e;
        acc = in_valid && (q.size() < 2) && !flush;
        pp  = out_ready && (q.size() > 0);
        e   = ref_decode(instr, rs_data, rt_data);
        last_held = in_valid && !acc && !flush;
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.aluop", {27'd0, aluop}, {27'd0, `ALUOP_ADD});
        check("rst.src1", src1, 32'd0);
        check("rst.src2", src2, 32'd0);
        check("rst.shamt", {27'd0, shamt}, 32'd0);
        check("rst.illegal", {31'd0, illegal}, 32'd0);

        // ADD stream
        instr = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        step();
        check("add.aluop", {27'd0, aluop}, {27'd0, `ALUOP_ADD});
        check("add.src1", src1, 32'd5);
        check("add.src2", src2, 32'd7);
        check("add.valid", {31'd0, out_valid}, 32'd1);

        // Immediate extension
        instr = {6'h08, 5'd1, 5'd2, 16'hFFFC}; rs_data = 32'd16;
        step();
        check("addi.src1", src1, 32'd16);
        check("addi.src2", src2, 32'hFFFFFFFC);
        instr = {6'h0D, 5'd1, 5'd2, 16'hFFFC};
        step();
        check("ori.aluop", {27'd0, aluop}, {27'd0, `ALUOP_ORI});
        check("ori.src2", src2, 32'h0000FFFC);
        instr = {6'h0F, 5'd0, 5'd2, 16'h1234}; rs_data = 32'hDEAD_BEEF;
        step();
        check("lui.src1", src1, 32'd0);
        check("lui.src2", src2, 32'h00001234);

        // SLL
        instr = 32'h00021100; rt_data = 32'd3;
        step();
        check("sll.aluop", {27'd0, aluop}, {27'd0, `ALUOP_SLL});
        check("sll.src1", src1, 32'd3);
        check("sll.shamt", {27'd0, shamt}, 32'd4);

        // Backpressure: A, B accepted; C held until space frees
        in_valid = 1'b0;
        step();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00221820; rt_data = 32'd1;
        rs_data = 32'h11; step();
        rs_data = 32'h22; step();
        check("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
        rs_data = 32'h33; step();
        check("bp.c_held", {31'd0, in_ready}, 32'd0);
        check("bp.head_a", src1, 32'h11);
        out_ready = 1'b1; step();
        check("bp.head_b", src1, 32'h22);
        step();
        check("bp.head_c", src1, 32'h33);
        in_valid = 1'b0; step();
        check("bp.drained", {31'd0, out_valid}, 32'd0);

        // Flush with two buffered entries and a same-cycle offer
        out_ready = 1'b0; in_valid = 1'b1; rs_data = 32'h44; step();
        rs_data = 32'h55; step();
        flush = 1'b1; rs_data = 32'h66; step();
        check("flush.out_valid", {31'd0, out_valid}, 32'd0);
        check("flush.in_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; step();
        check("flush.dropped", {31'd0, out_valid}, 32'd0);

        // Illegal opcode
        in_valid = 1'b1; out_ready = 1'b1; instr = {6'h3F, 26'h123_4567};
        rs_data = 32'hAAAA_5555; rt_data = 32'h1234_5678;
        step();
        check("ill.illegal", {31'd0, illegal}, 32'd1);
        check("ill.src1", src1, 32'd0);
        check("ill.src2", src2, 32'd0);
        check("ill.aluop", {27'd0, aluop}, {27'd0, `ALUOP_ADD});

        // Asynchronous reset between edges with two entries held
        out_ready = 1'b0; instr = 32'h00221820; rs_data = 32'h77; step();
        rs_data = 32'h88; step();
        #1 rst = 1'b1;
        #1;
        check("arst.out_valid", {31'd0, out_valid}, 32'd0);
        check("arst.in_ready", {31'd0, in_ready}, 32'd1);
        check("arst.src1", src1, 32'd0);
        #1 rst = 1'b0;
        q.delete();
        in_valid = 1'b1; out_ready = 1'b1; rs_data = 32'h99; step();
        check("arst.first_accept", src1, 32'h99);

        // Randomized traffic; held offers keep their payload stable
        for (int n = 0; n < 400; n++) begin
            if (!last_held) begin
                in_valid = ($urandom_range(0, 3) != 0);
                instr    = rand_instr();
                rs_data  = $urandom;
                rt_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
